// File: rtl/calc_arbiter.sv
// Round-robin arbiter that shares one RPN calculator among NUM_REQ token sources.
// Define ARB_TIMEOUT_EN to add a watchdog that drops a stalled grant (TIMEOUT_PULSE port).
module calc_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int RES_W          = 65,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         REQ_STB,
  input  logic [NUM_REQ*DATA_W-1:0]  REQ_DATA,
  input  logic [NUM_REQ-1:0]         REQ_IS_OP,
  output logic [NUM_REQ-1:0]         REQ_ACK,
  output logic [NUM_REQ-1:0]         RES_STB,
  output logic [RES_W-1:0]           RES_DATA,
  input  logic [NUM_REQ-1:0]         RES_ACK,
  output logic                       CALC_IN_STB,
  output logic [DATA_W-1:0]          CALC_IN_DATA,
  output logic                       CALC_IS_OP,
  input  logic                       CALC_IN_ACK,
  input  logic                       CALC_OUT_STB,
  input  logic [RES_W-1:0]           CALC_OUT_DATA,
  output logic                       CALC_OUT_ACK,
  output logic [$clog2(NUM_REQ)-1:0] GNT_ID,
  output logic [1:0]                 DBG_STATE
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                       TIMEOUT_PULSE
`endif
);

  localparam int GW = $clog2(NUM_REQ);

  // Handshake: a token moves when CALC_IN_STB && CALC_IN_ACK, a result when
  // CALC_OUT_STB && CALC_OUT_ACK, a delivery when RES_STB[gnt] && RES_ACK[gnt].
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DELIVER  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     last_q, last_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic              sel_stb;
  logic              sel_op;
  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              is_eq;
  logic [GW-1:0]     pick_idx;
  logic              pick_found;

  assign sel_stb  = REQ_STB[gnt_q];
  assign sel_op   = REQ_IS_OP[gnt_q];
  assign sel_data = REQ_DATA[int'(gnt_q)*DATA_W +: DATA_W];
  assign accept   = (state_q == ST_GRANT) && sel_stb && CALC_IN_ACK;
  assign is_eq    = sel_op && sel_data[2];

  assign RES_DATA  = res_q;
  assign GNT_ID    = gnt_q;
  assign DBG_STATE = state_q;

  // First requester after the last one served, wrapping around.
  always_comb begin
    logic [GW-1:0] idx;
    pick_idx   = last_q;
    pick_found = 1'b0;
    idx        = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = GW'((int'(last_q) + off) % NUM_REQ);
      if (!pick_found && REQ_STB[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timed;
  logic          progress;
  logic          fire;

  assign timed         = (state_q == ST_GRANT) || (state_q == ST_WAIT_RES);
  assign progress      = accept || ((state_q == ST_WAIT_RES) && CALC_OUT_STB);
  assign fire          = timed && !progress && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT_PULSE = fire;

  always_comb begin
    cnt_d = cnt_q;
    if (accept || (state_d != state_q)) cnt_d = '0;
    else if (timed)                     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    res_d        = res_q;
    REQ_ACK      = '0;
    RES_STB      = '0;
    CALC_IN_STB  = 1'b0;
    CALC_IN_DATA = '0;
    CALC_IS_OP   = 1'b0;
    CALC_OUT_ACK = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        CALC_IN_STB    = sel_stb;
        CALC_IN_DATA   = sel_data;
        CALC_IS_OP     = sel_op;
        REQ_ACK[gnt_q] = CALC_IN_ACK;
        if (accept && is_eq) state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (CALC_OUT_STB) begin
          CALC_OUT_ACK = 1'b1;
          res_d        = CALC_OUT_DATA;
          state_d      = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        RES_STB[gnt_q] = 1'b1;
        if (RES_ACK[gnt_q]) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    if (fire) begin
      last_d  = gnt_q;
      state_d = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: the bench plays both the token sources and the calculator.
// Also covers the ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_calc_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int RW = 65;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [NR-1:0]    REQ_STB;
  logic [NR*DW-1:0] REQ_DATA;
  logic [NR-1:0]    REQ_IS_OP;
  logic [NR-1:0]    REQ_ACK;
  logic [NR-1:0]    RES_STB;
  logic [RW-1:0]    RES_DATA;
  logic [NR-1:0]    RES_ACK;
  logic             CALC_IN_STB;
  logic [DW-1:0]    CALC_IN_DATA;
  logic             CALC_IS_OP;
  logic             CALC_IN_ACK;
  logic             CALC_OUT_STB;
  logic [RW-1:0]    CALC_OUT_DATA;
  logic             CALC_OUT_ACK;
  logic [1:0]       GNT_ID;
  logic [1:0]       DBG_STATE;
`ifdef ARB_TIMEOUT_EN
  logic             TIMEOUT_PULSE;
`endif

  calc_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .RES_W(RW)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_STB(REQ_STB), .REQ_DATA(REQ_DATA), .REQ_IS_OP(REQ_IS_OP), .REQ_ACK(REQ_ACK),
    .RES_STB(RES_STB), .RES_DATA(RES_DATA), .RES_ACK(RES_ACK),
    .CALC_IN_STB(CALC_IN_STB), .CALC_IN_DATA(CALC_IN_DATA), .CALC_IS_OP(CALC_IS_OP),
    .CALC_IN_ACK(CALC_IN_ACK), .CALC_OUT_STB(CALC_OUT_STB), .CALC_OUT_DATA(CALC_OUT_DATA),
    .CALC_OUT_ACK(CALC_OUT_ACK), .GNT_ID(GNT_ID), .DBG_STATE(DBG_STATE)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_PULSE(TIMEOUT_PULSE)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int oack_cnt = 0;
  logic [DW:0] exp_q[$];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every token reaching the calculator must be the next expected one.
  always @(negedge CLK) begin
    if (RST_N && CALC_IN_STB && CALC_IN_ACK) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL calc_token: unexpected token op=%0d data=0x%0h", CALC_IS_OP, CALC_IN_DATA);
      end else begin
        chk("calc_token", {CALC_IS_OP, CALC_IN_DATA}, exp_q.pop_front());
      end
    end
    if (CALC_OUT_ACK) oack_cnt++;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [NR-1:0]        mask;
    int                   req;
    int                   ntok;
    logic [3:0][DW-1:0]   d;
    logic [3:0]           op;
    logic [RW-1:0]        res;
    int                   pause_at;
    int                   pause_len;
    bit                   stall;
    bit                   abort;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [NR-1:0] mask, input int req, input int ntok,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                         input logic [3:0] op, input logic [RW-1:0] res,
                         input int pause_at, input int pause_len, input bit stall, input bit abort);
    vec_t v;
    v.mask = mask; v.req = req; v.ntok = ntok;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.op = op; v.res = res; v.pause_at = pause_at; v.pause_len = pause_len;
    v.stall = stall; v.abort = abort;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Starts and ends at a falling edge with the arbiter idle.
  task automatic do_expr(input vec_t v);
    int   r, k, cnt, guard, oack0;
    logic acc;
    r = v.req;
    for (int i = 0; i < v.ntok; i++) exp_q.push_back({v.op[i], v.d[i]});
    REQ_STB = v.mask;
    REQ_STB[r] = 1'b1;
    REQ_DATA[r*DW +: DW] = v.d[0];
    REQ_IS_OP[r] = v.op[0];
    CALC_IN_ACK = 1'b1;
    oack0 = oack_cnt;
    cnt = 0;
    do begin
      @(posedge CLK); #1;
      cnt++;
    end while (DBG_STATE != 2'd1 && cnt < 20);
    chk("arb_latency", cnt, 1);
    chk("gnt_id", GNT_ID, r);
    k = 0;
    guard = 0;
    @(negedge CLK);
    while (k < v.ntok && guard < 60) begin
      chk("req_ack", REQ_ACK, 4'(CALC_IN_ACK) << r);
      acc = REQ_ACK[r];
      @(posedge CLK); #1;
      guard++;
      if (acc) k++;
      if (k < v.ntok) begin
        if (acc && k == v.pause_at) begin
          REQ_STB[r] = 1'b0;
          for (int p = 0; p < v.pause_len; p++) begin
            @(negedge CLK);
            chk("pause_state", DBG_STATE, 2'd1);
            chk("pause_gnt", GNT_ID, r);
            chk("pause_in_stb", CALC_IN_STB, 0);
            @(posedge CLK); #1;
          end
          REQ_STB[r] = 1'b1;
        end
        REQ_DATA[r*DW +: DW] = v.d[k];
        REQ_IS_OP[r] = v.op[k];
        CALC_IN_ACK = v.stall ? (guard % 3 != 1) : 1'b1;
      end else begin
        REQ_STB[r] = v.mask[r];
      end
      @(negedge CLK);
    end
    CALC_IN_ACK = 1'b1;
    chk("tokens_done", k, v.ntok);
    chk("tokens_left", exp_q.size(), 0);
    chk("wait_state", DBG_STATE, 2'd2);
    chk("wait_in_stb", CALC_IN_STB, 0);
    // calculator latency of two cycles before the result appears
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    CALC_OUT_STB = 1'b1;
    CALC_OUT_DATA = v.res;
    @(negedge CLK);
    chk("out_ack", CALC_OUT_ACK, 1);
    @(posedge CLK); #1;
    CALC_OUT_STB = 1'b0;
    CALC_OUT_DATA = '0;
    @(negedge CLK);
    chk("out_ack_low", CALC_OUT_ACK, 0);
    chk("out_ack_pulses", oack_cnt - oack0, 1);
    chk("deliver_stb", RES_STB, 4'b1 << r);
    chk("deliver_data", RES_DATA, v.res);
    if (v.abort) begin
      #2 RST_N = 1'b0;
      #1;
      chk("rst_res_stb", RES_STB, 0);
      chk("rst_res_data", RES_DATA, 0);
      chk("rst_in_stb", CALC_IN_STB, 0);
      chk("rst_out_ack", CALC_OUT_ACK, 0);
      chk("rst_req_ack", REQ_ACK, 0);
      chk("rst_state", DBG_STATE, 0);
      chk("rst_gnt", GNT_ID, 0);
      REQ_STB = '0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(negedge CLK);
      return;
    end
    RES_ACK = ~(4'b1 << r);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("deliver_hold_stb", RES_STB, 4'b1 << r);
    chk("deliver_hold_data", RES_DATA, v.res);
    chk("deliver_hold_state", DBG_STATE, 2'd3);
    RES_ACK = 4'b1 << r;
    @(posedge CLK); #1;
    RES_ACK = '0;
    @(negedge CLK);
    chk("res_stb_clear", RES_STB, 0);
    chk("back_idle", DBG_STATE, 2'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    //       mask     req ntok d0      d1     d2     d3  op       result                  pause  stall abort
    add_vec(4'b1011, 0, 4, 32'd3,  32'd4, 32'd2, 32'd4, 4'b1100, 65'd7,                   -1, 0, 0, 0);
    add_vec(4'b1011, 1, 4, 32'd10, 32'd3, 32'd3, 32'd4, 4'b1100, 65'd7,                   -1, 0, 1, 0);
    add_vec(4'b1011, 3, 4, 32'd6,  32'd7, 32'd1, 32'd4, 4'b1100, 65'd42,                  -1, 0, 0, 0);
    add_vec(4'b1011, 0, 4, 32'd1,  32'd1, 32'd2, 32'd4, 4'b1100, 65'd2,                   -1, 0, 0, 0);
    add_vec(4'b1011, 1, 4, 32'd9,  32'd4, 32'd3, 32'd4, 4'b1100, 65'd5,                   -1, 0, 1, 0);
    add_vec(4'b1011, 3, 4, 32'd2,  32'd2, 32'd1, 32'd4, 4'b1100, 65'd4,                   -1, 0, 0, 0);
    add_vec(4'b0101, 0, 2, 32'd8,  32'd4, 32'd0, 32'd0, 4'b0010, 65'd8,                   -1, 0, 0, 0);
    add_vec(4'b0100, 2, 4, 32'd5,  32'd5, 32'd2, 32'd4, 4'b1100, 65'd10,                  -1, 0, 0, 0);
    add_vec(4'b0010, 1, 4, 32'd5,  32'd6, 32'd3, 32'd4, 4'b1100, 65'h1_FFFF_FFFF_FFFF_FFFF, 1, 10, 0, 0);
    add_vec(4'b0010, 1, 4, 32'd1,  32'd2, 32'd2, 32'd4, 4'b1100, 65'd3,                   -1, 0, 0, 1);
    add_vec(4'b1111, 0, 2, 32'd7,  32'd4, 32'd0, 32'd0, 4'b0010, 65'd7,                   -1, 0, 0, 0);

    RST_N = 1'b0;
    REQ_STB = '0; REQ_DATA = '0; REQ_IS_OP = '0; RES_ACK = '0;
    CALC_IN_ACK = 1'b0; CALC_OUT_STB = 1'b0; CALC_OUT_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_req_ack", REQ_ACK, 0);
    chk("reset_res_stb", RES_STB, 0);
    chk("reset_res_data", RES_DATA, 0);
    chk("reset_in_stb", CALC_IN_STB, 0);
    chk("reset_out_ack", CALC_OUT_ACK, 0);
    chk("reset_gnt", GNT_ID, 0);
    chk("reset_state", DBG_STATE, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // A stray calculator result and stray result acks while idle must be ignored.
    CALC_OUT_STB = 1'b1;
    CALC_OUT_DATA = 65'h123;
    RES_ACK = '1;
    @(negedge CLK);
    chk("stray_out_ack", CALC_OUT_ACK, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("stray_state", DBG_STATE, 0);
    chk("stray_res_stb", RES_STB, 0);
    chk("stray_res_data", RES_DATA, 0);
    CALC_OUT_STB = 1'b0;
    CALC_OUT_DATA = '0;
    RES_ACK = '0;

    foreach (vecs[i]) do_expr(vecs[i]);
    REQ_STB = '0;

`ifdef ARB_TIMEOUT_EN
    begin
      int cnt, j;
      exp_q.push_back({1'b0, 32'd5});
      REQ_STB = 4'b1100;
      REQ_DATA[2*DW +: DW] = 32'd5;
      REQ_IS_OP = '0;
      CALC_IN_ACK = 1'b1;
      cnt = 0;
      do begin
        @(posedge CLK); #1;
        cnt++;
      end while (DBG_STATE != 2'd1 && cnt < 20);
      @(negedge CLK);
      chk("to_gnt", GNT_ID, 2);
      chk("to_first_ack", REQ_ACK, 4'b0100);
      @(posedge CLK); #1;
      REQ_STB[2] = 1'b0;
      j = 0;
      do begin
        @(negedge CLK);
        j++;
      end while (!TIMEOUT_PULSE && j < 40);
      chk("to_cycles", j, 16);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("to_pulse_width", TIMEOUT_PULSE, 0);
      chk("to_no_res", RES_STB, 0);
      cnt = 0;
      do begin
        @(posedge CLK); #1;
        cnt++;
      end while (DBG_STATE != 2'd1 && cnt < 20);
      CALC_IN_ACK = 1'b0;
      REQ_STB = '0;
      chk("to_next_gnt", GNT_ID, 3);
      @(negedge CLK);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
Round-robin arbiter that shares a single RPN calculator among NUM_REQ token sources. It grants one requester at a time and forwards that requester's token stream to the calculator until the '=' token is accepted. It then collects the calculator's result and returns it to the granted requester before re-arbitrating. It sits between the client token sources and the calculator's input_stb/input_ack and output_stb/output_ack ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, token width; matches the calculator input
RES_W, 65, result width; matches the calculator output
TIMEOUT_CYCLES, 1024, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous reset, active-low
REQ_STB  in  NUM_REQ  per-requester token valid
REQ_DATA  in  NUM_REQ*DATA_W  tokens; requester i occupies bits [i*DATA_W +: DATA_W]
REQ_IS_OP  in  NUM_REQ  token is an operator
REQ_ACK  out  NUM_REQ  token accepted
RES_STB  out  NUM_REQ  result valid for requester i
RES_DATA  out  RES_W  shared result bus
RES_ACK  in  NUM_REQ  result taken
CALC_IN_STB  out  1  token valid to calculator
CALC_IN_DATA  out  DATA_W  token to calculator
CALC_IS_OP  out  1  operator flag to calculator
CALC_IN_ACK  in  1  calculator accepted token
CALC_OUT_STB  in  1  calculator result valid
CALC_OUT_DATA  in  RES_W  calculator result
CALC_OUT_ACK  out  1  result consumed
GNT_ID  out  clog2(NUM_REQ)  current/last granted index (debug)
TIMEOUT_PULSE  out  1  present only with ARB_TIMEOUT_EN

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; all outputs 0; RES_DATA 0; round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- Token encoding: operator with bit[2]=1 is '='. Bits[1:0] select the other operators: 01 mul, 10 add, 11 sub. Only '=' is decoded here.
- State IDLE: if any REQ_STB is high, pick the first set bit searching from last+1 with wrap-around. Register gnt, go GRANT. Arbitration takes 1 cycle; no token is forwarded in this cycle.
- State GRANT: combinational pass-through of the granted requester. CALC_IN_STB=REQ_STB[gnt], CALC_IN_DATA/CALC_IS_OP are muxed from gnt, REQ_ACK[gnt]=CALC_IN_ACK. All other REQ_ACK bits are 0; their REQ_STB is ignored and held off.
  - A token is accepted on a cycle where CALC_IN_STB and CALC_IN_ACK are both high.
  - Accepted token is '=': go WAIT_RES. Otherwise stay in GRANT.
  - A requester may drop REQ_STB between tokens; the grant is held until '='.
- State WAIT_RES: CALC_IN_STB=0. When CALC_OUT_STB=1, capture CALC_OUT_DATA into res_reg, pulse CALC_OUT_ACK for exactly 1 cycle, go DELIVER.
- State DELIVER: RES_STB[gnt]=1, RES_DATA=res_reg, held stable until RES_ACK[gnt]=1. On that cycle: RES_STB is 0 next cycle, last<=gnt, go IDLE. RES_ACK from other requesters is ignored.
- Minimum per-expression overhead: 1 cycle arbitration, 1 cycle capture, 1 cycle delivery beyond calculator latency.
- Fairness: a requester re-requesting right after service waits behind every other pending requester.
- CALC_OUT_STB outside WAIT_RES: ignored, no ack.
- Reset mid-operation: grant is dropped immediately and no partial result is delivered. Clearing calculator stack contents is the system's responsibility.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a counter is cleared on every accepted token and on entry to GRANT/WAIT_RES, and increments each cycle in GRANT or WAIT_RES. When it reaches TIMEOUT_CYCLES: TIMEOUT_PULSE=1 for 1 cycle, the grant is dropped, last<=gnt, state goes to IDLE, no RES_STB is raised.
- Undefined: no counter, no TIMEOUT_PULSE port; the grant is held indefinitely.

Test Plan:
- Reset, then requester 0 sends 3, 4, add(op 0b010), '='(op 0b100); calculator model returns 7 -> CALC_IN_DATA sequence 3,4,2,4; one CALC_OUT_ACK pulse; RES_STB[0]=1 with RES_DATA=7 until RES_ACK[0]; back to IDLE.
- REQ_STB[0] and REQ_STB[2] both high from reset -> requester 0 is served first, then 2; REQ_ACK[2] stays 0 throughout requester 0's transaction.
- Requesters 0, 1, 3 each requesting continuously for 2 expressions -> grant order 0, 1, 3, 0, 1, 3; GNT_ID matches.
- Requester 1 sends 5, pauses 10 cycles, sends 6, sub, '=' (result 0x1_FFFF_FFFF_FFFF_FFFF) -> grant held during the pause; full 65-bit value delivered intact.
- RST_N pulsed low while in DELIVER -> all RES_STB and CALC_* outputs are 0 asynchronously; the next arbitration starts from requester 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, requester 2 sends one token then stalls -> TIMEOUT_PULSE exactly 16 cycles after acceptance; requester 3 granted next.
